// File: rtl/robot_pkg.sv
// Shared types for the robot motor channel: command decode and driver states.
// Also holds the direction encoding used on the dir output.
package robot_pkg;

  typedef enum logic [1:0] {
    FWD = 2'd0,
    STP = 2'd1,
    REV = 2'd2,
    BAD = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DECEL = 2'd2,
    DEAD  = 2'd3
  } drv_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Anything other than exactly one line high is malformed.
  function automatic cmd_t decode_cmd(input logic f, input logic s, input logic r);
    cmd_t c;
    case ({f, s, r})
      3'b100:  c = FWD;
      3'b010:  c = STP;
      3'b001:  c = REV;
      default: c = BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/robot_pwm_gen.sv
// Free-running PWM counter and comparator; pwm registered, one cycle after duty/en.
// No backpressure: duty and en are sampled every cycle.
module robot_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                en,
  output logic                pwm
);

  logic [PWM_BITS-1:0] cnt_q;
  logic                pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      pwm_q <= en && (cnt_q < duty);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/robot_motor_driver.sv
// One DC motor channel: one-hot command -> ramped PWM, direction and brake, with dead-time.
// Commands take effect one cycle after sampling; no backpressure, inputs sampled every cycle.
module robot_motor_driver
  import robot_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int MAX_DUTY    = 200,
  parameter int RAMP_STEP   = 8,
  parameter int RAMP_DIV    = 4,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                forward,
  input  logic                stop,
  input  logic                reverse,
  output logic                pwm,
  output logic                dir,
  output logic                brake,
  output logic                at_speed,
  output logic                cmd_err,
  output logic [PWM_BITS-1:0] speed
);

  localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PWM_BITS:0]   MAX_W     = (PWM_BITS+1)'(MAX_DUTY);
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(RAMP_STEP);
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  cmd_t                cmd_in, cmd_q;
  drv_state_t          state_q, state_d;
  logic [PWM_BITS-1:0] speed_q, speed_d;
  logic                dir_q, dir_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic [DIV_W-1:0]    div_q;
  logic                cmd_err_q, brake_q, at_speed_q;
  logic                tick, match, pwm_en_d;
  logic [PWM_BITS:0]   speed_sum;
  logic [PWM_BITS-1:0] speed_up, speed_dn;

  assign cmd_in = decode_cmd(forward, stop, reverse);
  assign tick   = (div_q == DIV_LAST);
  assign match  = ((cmd_q == FWD) && (dir_q == DIR_FWD)) ||
                  ((cmd_q == REV) && (dir_q == DIR_REV));

  // Ramp arithmetic is one bit wider so saturation never sees a wrapped sum.
  assign speed_sum = {1'b0, speed_q} + STEP_W;
  assign speed_up  = (speed_sum > MAX_W) ? MAX_W[PWM_BITS-1:0] : speed_sum[PWM_BITS-1:0];
  assign speed_dn  = ({1'b0, speed_q} > STEP_W) ? (speed_q - STEP_W[PWM_BITS-1:0]) : '0;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        if (cmd_q == FWD) begin
          dir_d   = DIR_FWD;
          state_d = DRIVE;
        end else if (cmd_q == REV) begin
          dir_d   = DIR_REV;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (tick) speed_d = speed_up;
        if (!match) state_d = DECEL;
      end
      DECEL: begin
        if (tick) speed_d = speed_dn;
        // Reaching zero wins over a resume request in the same cycle.
        if (speed_d == '0) begin
          state_d = DEAD;
          dead_d  = DEAD_LOAD;
        end else if (match) begin
          state_d = DRIVE;
        end
      end
      DEAD: begin
        if (dead_q == '0) state_d = IDLE;
        else              dead_d  = dead_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // PWM gets next-state values so its register lines up with state_q and brake.
  assign pwm_en_d = (state_d == DRIVE) || (state_d == DECEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= STP;
      cmd_err_q  <= 1'b0;
      state_q    <= IDLE;
      speed_q    <= '0;
      dir_q      <= DIR_FWD;
      dead_q     <= '0;
      div_q      <= '0;
      brake_q    <= 1'b1;
      at_speed_q <= 1'b0;
    end else begin
      cmd_q      <= cmd_in;
      cmd_err_q  <= (cmd_in == BAD);
      state_q    <= state_d;
      speed_q    <= speed_d;
      dir_q      <= dir_d;
      dead_q     <= dead_d;
      div_q      <= tick ? '0 : div_q + 1'b1;
      brake_q    <= (state_d == IDLE) || (state_d == DEAD);
      at_speed_q <= (state_d == DRIVE) && (speed_d == MAX_W[PWM_BITS-1:0]);
    end
  end

  robot_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .duty (speed_d),
    .en   (pwm_en_d),
    .pwm  (pwm)
  );

  assign dir      = dir_q;
  assign brake    = brake_q;
  assign at_speed = at_speed_q;
  assign cmd_err  = cmd_err_q;
  assign speed    = speed_q;

endmodule

// File: tb/tb_robot_motor_driver.sv
// Scoreboard bench for robot_motor_driver: a behavioural model predicts every cycle's outputs,
// a negedge monitor compares them and watches the brake/pwm and direction safety rules.
module tb_robot_motor_driver;

  localparam int PB    = 8;
  localparam int MAXD  = 200;
  localparam int STEP  = 8;
  localparam int DIV   = 4;
  localparam int DEADC = 16;

  localparam int M_IDLE = 0, M_RUN = 1, M_SLOW = 2, M_HOLD = 3;
  localparam int C_F = 0, C_S = 1, C_R = 2, C_X = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic forward = 1'b0, stop = 1'b0, reverse = 1'b0;
  logic pwm, dir, brake, at_speed, cmd_err;
  logic [PB-1:0] speed;

  int checks = 0;
  int failures = 0;

  logic [PB+4:0] exp_q[$];

  // Model state: motion phase, speed as an integer, dead cycles still owed.
  int m_mode = M_IDLE, m_speed = 0, m_dead = 0, m_cmd = C_S, m_cyc = 0;
  bit m_dir = 1'b1;

  robot_motor_driver #(
    .PWM_BITS(PB), .MAX_DUTY(MAXD), .RAMP_STEP(STEP), .RAMP_DIV(DIV), .DEAD_CYCLES(DEADC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .forward(forward), .stop(stop), .reverse(reverse),
    .pwm(pwm), .dir(dir), .brake(brake), .at_speed(at_speed), .cmd_err(cmd_err), .speed(speed)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic [2:0] fsr, input logic rn, output logic [PB+4:0] e);
    bit tick, match, bad, p;
    if (!rn) begin
      m_mode = M_IDLE; m_speed = 0; m_dir = 1'b1; m_dead = 0; m_cmd = C_S; m_cyc = 0;
      e = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      return;
    end
    tick  = ((m_cyc % DIV) == DIV - 1);
    match = (m_cmd == C_F && m_dir) || (m_cmd == C_R && !m_dir);
    case (m_mode)
      M_IDLE: begin
        if (m_cmd == C_F) begin m_dir = 1'b1; m_mode = M_RUN; end
        else if (m_cmd == C_R) begin m_dir = 1'b0; m_mode = M_RUN; end
      end
      M_RUN: begin
        if (tick) m_speed = (m_speed + STEP > MAXD) ? MAXD : m_speed + STEP;
        if (!match) m_mode = M_SLOW;
      end
      M_SLOW: begin
        if (tick) m_speed = (m_speed > STEP) ? m_speed - STEP : 0;
        if (m_speed == 0) begin m_mode = M_HOLD; m_dead = DEADC; end
        else if (match) m_mode = M_RUN;
      end
      default: begin
        m_dead = m_dead - 1;
        if (m_dead == 0) m_mode = M_IDLE;
      end
    endcase
    p   = ((m_cyc % 256) < m_speed) && (m_mode == M_RUN || m_mode == M_SLOW);
    bad = ($countones(fsr) != 1);
    m_cmd = bad ? C_X : fsr[2] ? C_F : fsr[1] ? C_S : C_R;
    m_cyc = m_cyc + 1;
    e = {p, m_dir, (m_mode == M_IDLE || m_mode == M_HOLD),
         (m_mode == M_RUN && m_speed == MAXD), bad, 8'(m_speed)};
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic step(input logic [2:0] fsr, input logic rn);
    logic [PB+4:0] e;
    if (!rn && rst_n) begin @(negedge clk); #1; end
    {forward, stop, reverse} = fsr;
    rst_n = rn;
    model_step(fsr, rn, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    logic [PB+4:0] e, act;
    bit prev_ok = 1'b0, prev_dir = 1'b1, prev_pwm = 1'b0;
    int prev_speed = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pwm, dir, brake, at_speed, cmd_err, speed};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t got pwm,dir,brk,at,err,spd=%b_%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%b_%0d",
                   $time, act[12], act[11], act[10], act[9], act[8], act[7:0],
                   e[12], e[11], e[10], e[9], e[8], e[7:0]);
        end
      end
      if (rst_n && prev_ok) begin
        checks++;
        if (brake && pwm) begin
          failures++;
          $display("FAIL overlap: brake=%b pwm=%b required not both at %0t", brake, pwm, $time);
        end
        if (dir != prev_dir) begin
          checks++;
          if (prev_speed != 0 || prev_pwm) begin
            failures++;
            $display("FAIL dir_change: dir %b->%b with speed=%0d pwm=%b, required speed 0 pwm 0",
                     prev_dir, dir, prev_speed, prev_pwm);
          end
        end
      end
      prev_ok = rst_n; prev_dir = dir; prev_pwm = pwm; prev_speed = int'(speed);
    end
  end

  // Stimulus
  initial begin
    int n, cnt, spd0;
    bit found, done;
    logic [2:0] rot, v;
    @(posedge clk); #1;
    repeat (3) step(3'b000, 1'b0);
    check("reset_brake", brake, 1);
    check("reset_dir", dir, 1);

    // Ramp up forward.
    n = 0; found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      step(3'b100, 1'b1); n++;
      if (at_speed) found = 1'b1;
    end
    check("at_speed_reached", found, 1);
    check("at_speed_by_105", (n <= 105), 1);
    check("speed_max", speed, MAXD);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(3'b100, 1'b1); cnt += pwm; end
    check("pwm_duty_count", cnt, MAXD);

    // Stop to idle.
    for (int i = 0; i < 130; i++) step(3'b010, 1'b1);
    check("stop_speed0", speed, 0);
    check("stop_brake", brake, 1);
    check("stop_pwm0", pwm, 0);

    // Forward to speed, then reverse held.
    found = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin step(3'b100, 1'b1); if (at_speed) found = 1'b1; end
    check("fwd_again_at_speed", found, 1);
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step(3'b001, 1'b1);
      cnt += brake;
      if (dir == 1'b0 && !brake) done = 1'b1;
    end
    check("reverse_entered", done, 1);
    check("dead_plus_idle_brake", cnt, DEADC + 1);
    check("reverse_speed_from0", speed, 0);

    // Resume from mid-deceleration.
    for (int i = 0; i < 150; i++) step(3'b010, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin step(3'b100, 1'b1); if (speed >= 120) found = 1'b1; end
    check("reach_120", found, 1);
    for (int i = 0; i < 6; i++) step(3'b010, 1'b1);
    spd0 = int'(speed);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(3'b100, 1'b1); cnt += brake; end
    check("resume_no_brake", cnt, 0);
    check("resume_dir", dir, 1);
    check("resume_climbs", (int'(speed) > spd0), 1);

    // Malformed commands while driving.
    cnt = 0;
    for (int i = 0; i < 3; i++) begin step(3'b000, 1'b1); cnt += cmd_err; end
    for (int i = 0; i < 3; i++) begin step(3'b110, 1'b1); cnt += cmd_err; end
    step(3'b100, 1'b1); cnt += cmd_err;
    check("cmd_err_cycles", cnt, 6);
    check("cmd_err_cleared", cmd_err, 0);

    // Randomised sequencer-like traffic with a reset pulse in the middle.
    rot = 3'b100;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        step(3'b100, 1'b0);
        check("midreset_outputs", {pwm, dir, brake, at_speed, cmd_err, speed}, 13'h0C00);
        step(3'b100, 1'b0);
      end
      if ($urandom_range(0, 9) < 7) begin
        rot = {rot[0], rot[2:1]};
        v = rot;
      end else begin
        v = 3'($urandom_range(0, 7));
      end
      n = $urandom_range(1, 50);
      for (int k = 0; k < n; k++) step(v, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/robot_motor_driver.md
Name: robot_motor_driver

Overview:
Downstream consumer of the robot traffic-light sequencer. It takes the one-hot forward/stop/reverse command lines and drives one DC motor channel as PWM plus direction and brake outputs. It enforces safe motion: speed ramps up and down, direction only changes at zero speed, and a dead-time follows every stop. Malformed commands are rejected.

Parameters:
PWM_BITS, 8, width of the PWM counter and of the speed register.
MAX_DUTY, 200, target duty in DRIVE; must be <= 2^PWM_BITS-1.
RAMP_STEP, 8, speed increment or decrement per ramp tick.
RAMP_DIV, 4, clock cycles per ramp tick; must be >= 1.
DEAD_CYCLES, 16, braked idle cycles after speed reaches 0.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
forward  in  1  command: drive forward.
stop  in  1  command: decelerate and hold.
reverse  in  1  command: drive in reverse.
pwm  out  1  motor enable PWM, registered.
dir  out  1  1 = forward, 0 = reverse; registered.
brake  out  1  high in IDLE and DEAD.
at_speed  out  1  high when in DRIVE and speed == MAX_DUTY.
cmd_err  out  1  one-cycle pulse for a non-one-hot command.
speed  out  PWM_BITS  current duty value, for monitoring.

Behaviour:
- Reset (async assert, sync release): state=IDLE, speed=0, dir=1, pwm=0, brake=1, at_speed=0, cmd_err=0, all counters 0.
- Command decode: {forward,stop,reverse} is registered each cycle into cmd_q (FWD/STP/REV/BAD), giving 1 cycle of latency.
  - BAD means zero or more than one line high. BAD is treated as STP.
  - cmd_err goes high the cycle after a BAD sample and stays high for each consecutive BAD cycle.
- Ramp prescaler: free-running 0..RAMP_DIV-1. tick is high when it equals RAMP_DIV-1.
- State machine:
  - IDLE:
    - cmd_q=FWD: dir<=1, go to DRIVE.
    - cmd_q=REV: dir<=0, go to DRIVE.
    - Otherwise stay in IDLE.
    - This is the only place dir may change.
  - DRIVE:
    - On each tick, speed <= min(speed+RAMP_STEP, MAX_DUTY), saturating with no overflow.
    - cmd_q matching dir: stay in DRIVE.
    - STP, BAD, or the opposite direction: go to DECEL.
  - DECEL:
    - On each tick, speed <= max(speed-RAMP_STEP, 0).
    - cmd_q matching dir: return to DRIVE from the current speed.
    - Once speed==0 (checked every cycle): go to DEAD and load the dead counter with DEAD_CYCLES-1.
  - DEAD:
    - Counter decrements each cycle; commands are ignored.
    - Counter at 0: go to IDLE. Total dwell is exactly DEAD_CYCLES cycles.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps.
  - pwm <= (pwm_cnt < speed) && state in {DRIVE, DECEL}.
  - speed=0 forces pwm=0. MAX_DUTY=255 with 8 bits gives 255/256 duty.
- Invariants:
  - dir never changes while speed != 0 or while pwm=1.
  - brake and pwm are never high in the same cycle.
- Simultaneous events: a tick that takes speed to 0 enters DEAD on the next cycle. A matching command in that same cycle does not resume DRIVE.
- Reset mid-operation: all outputs return to reset values immediately (pwm drops asynchronously).

Decomposition:
- Shared package robot_pkg:
  - cmd_t enum: FWD, STP, REV, BAD.
  - drv_state_t enum: IDLE, DRIVE, DECEL, DEAD.
  - Direction constants DIR_FWD=1 and DIR_REV=0.
- Sub-module robot_pwm_gen holds the PWM counter and comparator: clk, rst_n, duty[PWM_BITS], en in; pwm out.
- The FSM, ramp, and dead-time logic stay in the top module.

Test Plan:
- Reset, then hold forward=1 -> dir=1; speed rises 8 per 4 cycles; at_speed=1 and speed=200 within 1+100+4 cycles; pwm is high 200 of every 256 cycles.
- At speed forward, then stop=1 -> speed falls to 0 in 25 ticks; brake=1 for exactly 16 cycles in DEAD, then IDLE with brake=1 and pwm=0.
- At speed forward, then reverse=1 held -> dir stays 1 until speed=0 plus 16 DEAD cycles; dir=0 the cycle DRIVE is entered; speed ramps from 0.
- During DECEL from speed=120, forward reasserted -> returns to DRIVE with no DEAD and no dir change; speed climbs from its current value.
- Inputs 3'b000 and 3'b110 for 3 cycles while driving -> cmd_err high for 3 cycles (lagged 1); enters DECEL.
- Feed the sequencer's rotating forward/stop/reverse each cycle, then pulse rst_n low mid-ramp -> no brake&pwm overlap, no dir change with speed != 0; all outputs at reset values while rst_n=0.
